// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the iterative divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam int DIV_MAX_W = 64;
  localparam logic [DIV_MAX_W-1:0] DIV_ZERO_QUOT = '1;

  function automatic int div_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division iteration.
// Revision : 1.0
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Partial remainder is always below the divisor, so WIDTH+1 bits cannot overflow.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_dvs};

  assign o_rem = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/div32_iter.sv
`default_nettype none
// ============================================================================
// Module   : div32_iter
// Brief    : Iterative restoring divider, one quotient bit per clock.
//            Optional abort input enabled by defining DIV32_ABORT_EN.
// Revision : 1.0
// ============================================================================
module div32_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_dvs_zero;
  logic             w_last;
  logic             w_abort;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept   = start && (r_state != S_BUSY);
  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH - 1));

`ifdef DIV32_ABORT_EN
  assign w_abort = abort && (r_state == S_BUSY);
`else
  assign w_abort = 1'b0;
`endif

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? ('0 - dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? ('0 - divisor)  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  assign w_quo_fix = r_neg_q ? ('0 - w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? ('0 - w_rem_nxt) : w_rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_dvs_zero ? S_DONE : S_BUSY;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (w_abort)     w_state_nxt = S_IDLE;
          else if (w_last) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_rem   <= '0;
      r_quo   <= w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_cnt   <= '0;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      // Zero divisor skips iteration and publishes the fixed result at once.
      if (w_dvs_zero) begin
        r_quotient  <= DIV_ZERO_QUOT[WIDTH-1:0];
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end
    end else if ((r_state == S_BUSY) && !w_abort) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_quotient  <= w_quo_fix;
        r_remainder <= w_rem_fix;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == S_BUSY);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div32_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div32_iter
// Brief    : Directed scoreboard bench for div32_iter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_div32_iter;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         start     = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend  = '0;
  logic [W-1:0] divisor   = '0;
`ifdef DIV32_ABORT_EN
  logic         abort     = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last_res = '0;

  always #5 clk = ~clk;

  div32_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV32_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Truncating-division reference built from magnitudes in 64-bit arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t        e;
    bit          na, nb;
    logic [63:0] ma, mb, q, r;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
      return e;
    end
    na = s && a[W-1];
    nb = s && b[W-1];
    ma = na ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    mb = nb ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = 64'h0 - q;
    if (na)      r = 64'h0 - r;
    e.q = q[W-1:0]; e.r = r[W-1:0]; e.z = 1'b0;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input exp_t e);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    sb.push_back(e);
    step();
    start = 1'b0;
    if (b == '0) chk("dz_done_next_cycle", {31'h0, done}, 32'd1);
    else         chk("accept_busy", {31'h0, busy}, 32'd1);
  endtask

  task automatic wait_result(input int exp_lat, input bit poke);
    int   n = 0;
    bit   busy_bad = 1'b0;
    exp_t e;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (poke && n == 5) begin
        start = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'h3; is_signed = 1'b1;
      end else if (poke && n == 6) begin
        start = 1'b0; dividend = 32'h1; divisor = 32'h1;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk("latency", n, exp_lat);
    chk("busy_during_divide", {31'h0, busy_bad}, 32'd0);
    chk("busy_low_at_done", {31'h0, busy}, 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.z});
      last_res = e;
    end
  endtask

  initial begin
    exp_t e;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'h0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    step();

    // Unsigned 100/7 with an ignored start pulse mid-divide
    e.q = 32'd14; e.r = 32'd2; e.z = 1'b0;
    issue(32'd100, 32'd7, 1'b0, e);
    wait_result(W, 1'b1);
    step();
    chk("done_one_cycle", {31'h0, done}, 32'd0);
    chk("idle_after_done", {31'h0, busy}, 32'd0);

    // Signed -100/7
    e.q = 32'hFFFF_FFF2; e.r = 32'hFFFF_FFFE; e.z = 1'b0;
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, e);
    wait_result(W, 1'b0);

    // Back-to-back from the DONE cycle: signed overflow case
    e.q = 32'h8000_0000; e.r = 32'h0; e.z = 1'b0;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e);
    wait_result(W, 1'b0);

    // Divide by zero, both modes
    step();
    e.q = 32'hFFFF_FFFF; e.r = 32'h1234; e.z = 1'b1;
    issue(32'h1234, 32'h0, 1'b0, e);
    wait_result(0, 1'b0);
    issue(32'h1234, 32'h0, 1'b1, e);
    wait_result(0, 1'b0);

    // Mixed-sign and random operands against the reference model
    issue(32'd100, 32'hFFFF_FFF9, 1'b1, model(32'd100, 32'hFFFF_FFF9, 1'b1));
    wait_result(W, 1'b0);
    issue(32'hFFFF_FFFF, 32'd10, 1'b0, model(32'hFFFF_FFFF, 32'd10, 1'b0));
    wait_result(W, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a, b;
      bit           s;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == '0) b = 32'd3;
      s = i[0];
      issue(a, b, s, model(a, b, s));
      wait_result(W, 1'b0);
    end

`ifdef DIV32_ABORT_EN
    // Abort mid-divide: back to IDLE, no done, previous results retained
    step();
    issue(32'd5000, 32'd3, 1'b0, model(32'd5000, 32'd3, 1'b0));
    repeat (9) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_keep_q", quotient, last_res.q);
    chk("abort_keep_r", remainder, last_res.r);
    void'(sb.pop_back());
    begin
      bit seen = 1'b0;
      repeat (35) begin
        step();
        if (done) seen = 1'b1;
      end
      chk("abort_no_done", {31'h0, seen}, 32'd0);
    end
`endif

    // Asynchronous reset mid-divide
    step();
    issue(32'd100, 32'd7, 1'b0, model(32'd100, 32'd7, 1'b0));
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_done", {31'h0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'h0, div_by_zero}, 32'd0);
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      repeat (35) begin
        step();
        if (done) seen = 1'b1;
      end
      chk("midrst_no_done", {31'h0, seen}, 32'd0);
    end

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div32_iter.md
Name: div32_iter

Overview:
- Multi-cycle iterative restoring divider for the CPU execute stage, paired with the combinational adders.
- Produces a 32-bit quotient and remainder, signed or unsigned.
- Fixed latency of one quotient bit per clock.
- Start/done handshake, so the pipeline controller stalls while `busy` is high.

Parameters:
- WIDTH, 32, operand/result width in bits; the counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high while in BUSY
- done  output  1  one-cycle pulse in DONE; results valid
- quotient  output  WIDTH  result quotient; held until the next accepted start
- remainder  output  WIDTH  result remainder; held until the next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with the results

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers are cleared.
  - Reset mid-operation abandons the divide with no done pulse.
- States:
  - IDLE -> BUSY on start (divisor != 0).
  - IDLE -> DONE on start (divisor == 0).
  - BUSY -> DONE after WIDTH steps.
  - DONE -> IDLE unconditionally, or DONE -> BUSY/DONE if start is asserted in DONE (back-to-back issue).
- Accept edge:
  - Latch |dividend| and |divisor| (magnitudes when is_signed, raw values otherwise).
  - Latch neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both forced 0 when unsigned.
  - Clear the partial remainder and set count=0.
- BUSY step, one per edge:
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - divisor_mag, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo LSB = 1; otherwise quo LSB = 0.
  - count increments.
- Completion edge (count == WIDTH-1):
  - quotient = neg_q ? -quo : quo.
  - remainder = neg_r ? -rem : rem.
  - Both outputs are registered on this edge.
  - done=1 for exactly the following cycle.
- Latency:
  - Start sampled at edge E0; done is visible after edge E(WIDTH), i.e. 32 cycles later.
  - busy is high for cycles E0..E(WIDTH) and drops as done rises.
- Start handling:
  - start is ignored while busy.
  - Operand changes while busy have no effect.
- Divide by zero (no iteration):
  - Transition straight to DONE on the accept edge; done appears 1 cycle after start.
  - quotient = all ones, remainder = dividend (raw, unmodified), div_by_zero=1.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed):
  - quotient = 0x80000000, remainder = 0, no flag.
  - This is the natural result of magnitude arithmetic and needs no special casing.
- Sign of the remainder always follows the dividend (truncating division).

Optional Feature:
- Macro: DIV32_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit).
  - abort high in BUSY returns the block to IDLE on the next edge: busy=0, no done, outputs keep their previous values.
  - abort in IDLE or DONE is ignored.
  - abort and start in the same cycle in DONE: abort is ignored and start is accepted.
- When undefined:
  - No port.
  - Every accepted divide runs to completion.

Decomposition:
- Package div_pkg:
  - State enum {IDLE, BUSY, DONE} (2-bit encoding).
  - Localparam DIV_ZERO_QUOT = all ones.
  - Count-width function.
- Sub-module div_step:
  - Purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor_mag. Outputs: next rem, next quo.
  - Instanced once in div32_iter.
  - Unit-testable standalone.
- Sign-fix negation is done inline in the top with two's-complement.

Test Plan:
- Unsigned 100 / 7, start for 1 cycle -> done after exactly 32 cycles; quotient=14, remainder=2; busy high throughout the divide.
- Signed -100 / 7 (0xFFFFFF9C / 7) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- Divide by zero, 0x1234 / 0 (both modes) -> done 1 cycle after start; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Back-to-back: second start asserted in the DONE cycle -> first results seen on done, second divide accepted with no idle gap. Also: start pulses while busy are ignored.
- rst_n dropped mid-BUSY (cycle 10) -> all outputs 0 immediately, no done. With DIV32_ABORT_EN: abort at cycle 10 -> IDLE next edge, no done, previous results retained.
